// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Sequential unsigned restoring divider. Produces one quotient bit
//            per clock using a start/busy/done handshake. Runs beside the
//            combinational array multiplier in the arithmetic datapath.
//
// Ports    : clk    in   1  clock, rising edge
//            rst    in   1  asynchronous, active-high reset
//            start  in   1  request, sampled only when not busy
//            a      in   W  dividend, sampled on the accepting edge
//            b      in   W  divisor, sampled on the accepting edge
//            busy   out  1  high while iterating
//            done   out  1  one-cycle pulse when quo/rem/dz are updated
//            quo    out  W  quotient, held until the next done
//            rem    out  W  remainder, held until the next done
//            dz     out  1  divide-by-zero flag, valid with done
//
// Options  : DIV_ZERO_FAST_EN - when defined, a zero divisor skips the
//            iteration and completes one cycle after acceptance without
//            raising busy. Results are identical in both builds.
//
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dz
);

    localparam int CW = $clog2(W + 1);

    // Counter value seen on the final iteration edge.
    localparam logic [CW-1:0] c_last = CW'(W - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;

    // Partial remainder. The arithmetic P is W+1 bits wide, but its top bit
    // is always zero between iterations (P < b for non-zero b, and P holds a
    // prefix of a shorter than W bits when b is zero), so only the low W bits
    // are stored. The extra bit exists only in the trial subtraction below.
    logic [W-1:0]   r_p;
    logic [W-1:0]   r_q;     // dividend shifting out, quotient shifting in
    logic [W-1:0]   r_b;     // latched divisor
    logic [CW-1:0]  r_cnt;

    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_rem;
    logic           r_dz;

    // ------------------------------------------------------------------
    // One restoring step: shift P:Q left, trial-subtract the divisor and
    // keep the difference only when it is non-negative.
    // ------------------------------------------------------------------
    logic [W:0]     w_p_sh;
    logic [W-1:0]   w_q_sh;
    logic [W:0]     w_t;
    logic [W-1:0]   w_p_nxt;
    logic [W-1:0]   w_q_nxt;
    logic           w_fast_dz;

    always_comb begin
        w_p_sh  = {r_p, r_q[W-1]};
        w_q_sh  = {r_q[W-2:0], 1'b0};
        w_t     = w_p_sh - {1'b0, r_b};
        w_p_nxt = w_p_sh[W-1:0];
        w_q_nxt = w_q_sh;
        // Sign bit of the W+1-bit difference: clear means P >= b.
        if (!w_t[W]) begin
            w_p_nxt = w_t[W-1:0];
            w_q_nxt = {w_q_sh[W-1:1], 1'b1};
        end
    end

`ifdef DIV_ZERO_FAST_EN
    assign w_fast_dz = (b == '0);
`else
    assign w_fast_dz = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                // DONE behaves like IDLE for acceptance so that a request
                // arriving in the done cycle is taken back-to-back.
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (start) begin
                        r_q   <= a;
                        r_b   <= b;
                        r_p   <= '0;
                        r_cnt <= '0;
                        if (w_fast_dz) begin
                            r_state <= S_ZERO;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_CALC: begin
                    r_p   <= w_p_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_quo   <= w_q_nxt;
                        r_rem   <= w_p_nxt;
                        r_dz    <= (r_b == '0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end

                // Zero-divisor shortcut: r_q still holds the dividend, which
                // is exactly the remainder the full iteration would produce.
                S_ZERO: begin
                    r_quo   <= '1;
                    r_rem   <= r_q;
                    r_dz    <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quo  = r_quo;
    assign rem  = r_rem;
    assign dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider (W=4). Table-driven vectors,
//            hand-written multi-cycle sequences and an exhaustive sweep, with
//            a scoreboard queue popped on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 4;

`ifdef DIV_ZERO_FAST_EN
    localparam bit c_fast = 1'b1;
`else
    localparam bit c_fast = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;

    seq_divider #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .quo   (quo),
        .rem   (rem),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dz;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } sb_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dz;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[8];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk($sformatf("quo a=%0d b=%0d", e.a, e.b), int'(quo), int'(e.quo));
                chk($sformatf("rem a=%0d b=%0d", e.a, e.b), int'(rem), int'(e.rem));
                chk($sformatf("dz a=%0d b=%0d", e.a, e.b), int'(dz), int'(e.dz));
            end
        end
    end

    // Issue one operation and measure done latency and busy cycles.
    // now=1 drives start in the current cycle (used from a done cycle).
    // glitch_at>=0 pulses start with a=b=15 at that cycle of the iteration.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ed, input bit now, input int glitch_at);
        int  n;
        int  nb;
        int  exp_lat;
        int  exp_busy;
        sb_t e;
        if (!now) @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        e.quo = eq; e.rem = er; e.dz = ed; e.a = ta; e.b = tbv;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = 'x;
        b     = 'x;
        n  = 0;
        nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            if (n == glitch_at) begin
                start = 1'b1;
                a     = 4'd15;
                b     = 4'd15;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start    = 1'b0;
        exp_lat  = (c_fast && tbv == '0) ? 1 : W;
        exp_busy = (c_fast && tbv == '0) ? 0 : W;
        chk($sformatf("latency a=%0d b=%0d", ta, tbv), n, exp_lat);
        chk($sformatf("busy_cycles a=%0d b=%0d", ta, tbv), nb, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{a: 4'd13, b: 4'd3,  quo: 4'd4,  rem: 4'd1,  dz: 1'b0};
        tbl[1] = '{a: 4'd9,  b: 4'd0,  quo: 4'd15, rem: 4'd9,  dz: 1'b1};
        tbl[2] = '{a: 4'd0,  b: 4'd5,  quo: 4'd0,  rem: 4'd0,  dz: 1'b0};
        tbl[3] = '{a: 4'd3,  b: 4'd7,  quo: 4'd0,  rem: 4'd3,  dz: 1'b0};
        tbl[4] = '{a: 4'd14, b: 4'd5,  quo: 4'd2,  rem: 4'd4,  dz: 1'b0};
        tbl[5] = '{a: 4'd15, b: 4'd15, quo: 4'd1,  rem: 4'd0,  dz: 1'b0};
        tbl[6] = '{a: 4'd0,  b: 4'd0,  quo: 4'd15, rem: 4'd0,  dz: 1'b1};
        tbl[7] = '{a: 4'd11, b: 4'd1,  quo: 4'd11, rem: 4'd0,  dz: 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quo",  int'(quo),  0);
        chk("reset_rem",  int'(rem),  0);
        chk("reset_dz",   int'(dz),   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].quo, tbl[i].rem, tbl[i].dz, 1'b0, -1);

        // Back-to-back: second request driven in the first op's done cycle.
        run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0, -1);
        run_op(4'd2,  4'd7, 4'd0,  4'd2, 1'b0, 1'b1, -1);

        // start pulsed during CALC must be ignored.
        run_op(4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0, 1);
        repeat (W + 3) @(negedge clk);
        chk("glitch_single_done", sb.size(), 0);

        // Reset in the middle of an operation: no done, outputs cleared.
        @(negedge clk);
        start = 1'b1;
        a     = 4'd14;
        b     = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midop_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quo",  int'(quo),  0);
        chk("midrst_rem",  int'(rem),  0);
        chk("midrst_dz",   int'(dz),   0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk("busy_after_rst", int'(busy), 0);
        run_op(4'd14, 4'd5, 4'd2, 4'd4, 1'b0, 1'b0, -1);

        // Exhaustive sweep against an arithmetic model.
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] xa;
            logic [W-1:0] xb;
            logic [W-1:0] mq;
            logic [W-1:0] mr;
            xa = 4'(i >> 4);
            xb = 4'(i);
            if (xb == '0) begin
                mq = '1;
                mr = xa;
            end else begin
                mq = xa / xb;
                mr = xa % xb;
            end
            run_op(xa, xb, mq, mr, (xb == '0), 1'b0, -1);
        end

        repeat (W + 3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's combinational array multiplier.
- Computes quotient and remainder of a W-bit dividend by a W-bit divisor, one quotient bit per clock.
- Uses a start/busy/done handshake and sits beside the multiplier in the arithmetic datapath.
- Over all legal inputs: quo*b + rem == a, with rem < b when b != 0.

Parameters:
W, 4, operand/result width in bits (W >= 2)
CW, $clog2(W+1), iteration counter width (derived; do not override)

Ports:
clk    input   1   clock; all state updates on rising edge
rst    input   1   reset, asynchronous, active-high
start  input   1   request; sampled only when not busy
a      input   W   dividend; sampled on the accepting edge only
b      input   W   divisor; sampled on the accepting edge only
busy   output  1   high while iterating
done   output  1   one-cycle pulse when quo/rem are updated
quo    output  W   quotient, registered, held until next done
rem    output  W   remainder, registered, held until next done
dz     output  1   divide-by-zero flag, registered, valid with done

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset (asserted at any time, including mid-operation):
  - State to IDLE.
  - busy=0, done=0, quo=0, rem=0, dz=0.
  - Internal partial remainder, shift register and counter cleared.
  - Any in-flight operation is discarded; no done is produced for it.
- States:
  - IDLE: busy=0. An edge with start=1 is the accept edge E0: latch a into the shift register, latch b into the divisor register, clear the partial remainder P (W+1 bits), set cnt=0, go to CALC.
  - CALC: busy=1. Each edge performs one restoring step:
    - Shift P:Q left by 1.
    - Compute T = P - {0,b}.
    - If T is non-negative (MSB 0): P=T and Q[0]=1. Otherwise restore P and Q[0]=0.
    - Increment cnt.
    - On the edge where cnt reaches W-1 (edge EW): write quo = final Q, rem = final P[W-1:0], dz = (b==0); set done=1; go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. On the next edge done=0 and the state goes to IDLE. If start=1 on that edge, it is accepted as a new E0 (back-to-back ops allowed).
- Latency: done is visible W cycles after E0; the accept-to-accept throughput is W+1 cycles.
- start is ignored in CALC; a and b are don't-care outside E0.
- quo, rem and dz change only on done edges or reset.
- Divisor zero without the optional feature: the algorithm runs naturally and yields quo = all ones, rem = a, dz = 1, with full W-cycle latency.
- Edge cases:
  - a=0 gives quo=0, rem=0.
  - b=1 gives quo=a, rem=0.
  - a<b gives quo=0, rem=a.
- No overflow is possible for unsigned operands.

Optional Feature:
DIV_ZERO_FAST_EN
- Defined:
  - At E0, if b==0, skip CALC and go straight to DONE.
  - quo = all ones, rem = a, dz = 1.
  - done is visible 1 cycle after E0.
  - busy never asserts for that operation.
- Undefined:
  - No shortcut; b==0 takes the full W cycles.
  - Results are identical (quo = all ones, rem = a, dz = 1).
- Non-zero divisors behave identically in both builds.

Test Plan:
- W=4, a=13, b=3, start one cycle -> busy high for 4 cycles; done pulse 4 cycles after accept; quo=4, rem=1, dz=0.
- a=15, b=1, then back-to-back start in the DONE cycle with a=2, b=7 -> first quo=15, rem=0; second accepted immediately, quo=0, rem=2, one done per op.
- a=9, b=0 -> quo=15, rem=9, dz=1.
  - Done latency 4 cycles without DIV_ZERO_FAST_EN.
  - Done latency 1 cycle with it, and busy stays 0.
- a=6, b=2 accepted; pulse start with a=15, b=15 during CALC -> ignored; quo=3, rem=0; only one done.
- a=14, b=5 accepted; assert rst after 2 CALC cycles -> all outputs 0 immediately; no done. After release, a=14, b=5 gives quo=2, rem=4.
- Exhaustive sweep over all 256 (a,b) pairs -> quo*b+rem==a and rem<b for b!=0; b==0 rows give quo=15, rem=a, dz=1.
